// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects the
// faster/slower/next push buttons for the bicycle light controller.
module button_conditioner #(
    parameter int N         = 3,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_pulse
);

    // state[1] doubles as the debounced level
    localparam logic [1:0] IDLE         = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] PRESSED      = 2'b10;
    localparam logic [1:0] RELEASE_WAIT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [1:0]   warm;

    // Two-flop synchronizer; warm marks when sync2 holds a real sample
    // rather than the reset value, so a button held through reset
    // cannot arm its channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            warm  <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            warm  <= {warm[0], 1'b1};
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [1:0]       state;
        logic [1:0]       state_nx;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic             armed;
        logic             pulse;
        logic             pulse_nx;

        // Debounce FSM next-state and counter logic
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            pulse_nx = 1'b0;
            case (state)
                IDLE: begin
                    if (sync2[i] && armed) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2[i]) begin
                        state_nx = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = PRESSED;
                        pulse_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync2[i]) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2[i]) begin
                        state_nx = PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        // Channel state, counter, arm flag and registered pulse
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
                armed <= 1'b0;
                pulse <= 1'b0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                armed <= armed | (warm[1] & ~sync2[i]);
                pulse <= pulse_nx;
            end
        end

        assign btn_level[i] = state[1];
        assign btn_pulse[i] = pulse;
    end

endmodule
